// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: single-cycle ALU results vs. a FIFO of long-latency results.
// Optional starvation guard for the FIFO is enabled by defining WB_STARVE_GUARD_EN.
module wb_write_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned XLEN         = 32,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    output logic                     alu_stall,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [4:0]               lsu_rd,
    input  logic [XLEN-1:0]          lsu_data,
    input  logic                     pend_set,
    input  logic [4:0]               pend_rd,
    output logic                     wr_en,
    output logic [4:0]               wr_rd,
    output logic [XLEN-1:0]          wr_data,
    output logic [31:0]              pending,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_param
        $error("wb_write_arbiter: DEPTH must be a power of 2 >= 2 and STARVE_LIMIT >= 1");
    end

    logic [4:0]      r_mem_rd   [DEPTH];
    logic [XLEN-1:0] r_mem_data [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [31:0]     r_pending;
    logic            r_wr_en;
    logic [4:0]      r_wr_rd;
    logic [XLEN-1:0] r_wr_data;

    logic            w_push;
    logic            w_pop;
    logic            w_alu_win;
    logic            w_fifo_empty;
    logic [31:0]     w_pend_next;

    assign w_fifo_empty = (r_count == '0);
    assign lsu_ready    = !rst && (r_count < CW'(DEPTH));
    assign w_push       = lsu_valid && lsu_ready;
    assign w_alu_win    = alu_valid && !alu_stall;
    assign w_pop        = !w_alu_win && !w_fifo_empty;

`ifdef WB_STARVE_GUARD_EN
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] r_starve;

    assign alu_stall = (r_starve == SW'(STARVE_LIMIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
        end else if (w_pop || w_fifo_empty) begin
            r_starve <= '0;
        end else if (w_alu_win) begin
            r_starve <= r_starve + 1'b1;
        end
    end
`else
    assign alu_stall = 1'b0;
`endif

    // Storage is not reset: entries are only ever read below the tail pointer.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rd[r_wptr]   <= lsu_rd;
            r_mem_data[r_wptr] <= lsu_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Clear first, then set, so a re-issue to the same register keeps its bit.
    always_comb begin
        w_pend_next = r_pending;
        if (w_pop) w_pend_next[r_mem_rd[r_rptr]] = 1'b0;
        if (pend_set && pend_rd != 5'd0) w_pend_next[pend_rd] = 1'b1;
        w_pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pend_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_rd   <= '0;
            r_wr_data <= '0;
        end else if (w_alu_win) begin
            r_wr_en   <= (alu_rd != 5'd0);
            r_wr_rd   <= alu_rd;
            r_wr_data <= alu_data;
        end else if (w_pop) begin
            r_wr_en   <= (r_mem_rd[r_rptr] != 5'd0);
            r_wr_rd   <= r_mem_rd[r_rptr];
            r_wr_data <= r_mem_data[r_rptr];
        end else begin
            r_wr_en   <= 1'b0;
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_rd      = r_wr_rd;
    assign wr_data    = r_wr_data;
    assign pending    = r_pending;
    assign fifo_count = r_count;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: per-cycle vector table through a scoreboard queue, plus
// hand sequences for hold, async reset mid-stream and (with WB_STARVE_GUARD_EN) the starve guard.
module tb_wb_write_arbiter;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_stall;
    logic            lsu_valid;
    logic            lsu_ready;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            pend_set;
    logic [4:0]      pend_rd;
    logic            wr_en;
    logic [4:0]      wr_rd;
    logic [XLEN-1:0] wr_data;
    logic [31:0]     pending;
    logic [2:0]      fifo_count;

    int n_cmp = 0;
    int n_err = 0;

    wb_write_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .pend_set(pend_set), .pend_rd(pend_rd),
        .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data),
        .pending(pending), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        av;  logic [4:0] ard; logic [31:0] ad;
        logic        lv;  logic [4:0] lrd; logic [31:0] ld;
        logic        ps;  logic [4:0] prd;
        logic        en;  logic [4:0] rd;  logic [31:0] data;
        int          cnt; logic       rdy; logic [31:0] pend;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                                input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                                input logic ps, input logic [4:0] prd,
                                input logic en, input logic [4:0] rd, input logic [31:0] data,
                                input int cnt, input logic rdy, input logic [31:0] pend);
        vec_t v;
        v.av = av; v.ard = ard; v.ad = ad; v.lv = lv; v.lrd = lrd; v.ld = ld;
        v.ps = ps; v.prd = prd; v.en = en; v.rd = rd; v.data = data;
        v.cnt = cnt; v.rdy = rdy; v.pend = pend;
        return v;
    endfunction

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        pend_set  = 1'b0; pend_rd = '0;
    endtask

    localparam logic [31:0] P7  = 32'h0000_0080;
    localparam logic [31:0] P11 = 32'h0000_0800;

    initial begin
        vec_t e;
        rst = 1'b1;
        idle_inputs();

        //           av ard  ad            lv lrd  ld            ps prd   en rd  data          cnt rdy pend
        vecs.push_back(mk(0, 0,  0,            0, 0,  0,            0, 0,    0, 0,  0,            0, 1, 0));
        vecs.push_back(mk(1, 5,  32'hDEADBEEF, 0, 0,  0,            0, 0,    1, 5,  32'hDEADBEEF, 0, 1, 0));
        vecs.push_back(mk(1, 0,  32'h12345678, 0, 0,  0,            0, 0,    0, 0,  0,            0, 1, 0));
        vecs.push_back(mk(0, 0,  0,            0, 0,  0,            1, 7,    0, 0,  0,            0, 1, P7));
        vecs.push_back(mk(1, 1,  32'hA1,       1, 1,  32'h100,      0, 0,    1, 1,  32'hA1,       1, 1, P7));
        vecs.push_back(mk(1, 2,  32'hA2,       1, 2,  32'h200,      0, 0,    1, 2,  32'hA2,       2, 1, P7));
        vecs.push_back(mk(1, 3,  32'hA3,       1, 3,  32'h300,      0, 0,    1, 3,  32'hA3,       3, 1, P7));
        vecs.push_back(mk(1, 4,  32'hA4,       1, 4,  32'h400,      0, 0,    1, 4,  32'hA4,       4, 0, P7));
        vecs.push_back(mk(1, 6,  32'hA6,       1, 9,  32'h999,      0, 0,    1, 6,  32'hA6,       4, 0, P7));
        vecs.push_back(mk(0, 0,  0,            0, 0,  0,            0, 0,    1, 1,  32'h100,      3, 1, P7));
        vecs.push_back(mk(0, 0,  0,            0, 0,  0,            0, 0,    1, 2,  32'h200,      2, 1, P7));
        vecs.push_back(mk(0, 0,  0,            0, 0,  0,            0, 0,    1, 3,  32'h300,      1, 1, P7));
        vecs.push_back(mk(0, 0,  0,            0, 0,  0,            0, 0,    1, 4,  32'h400,      0, 1, P7));
        vecs.push_back(mk(0, 0,  0,            0, 0,  0,            0, 0,    0, 0,  0,            0, 1, P7));
        vecs.push_back(mk(0, 0,  0,            1, 7,  32'h777,      0, 0,    0, 0,  0,            1, 1, P7));
        vecs.push_back(mk(0, 0,  0,            0, 0,  0,            0, 0,    1, 7,  32'h777,      0, 1, 0));
        vecs.push_back(mk(0, 0,  0,            1, 7,  32'h7770,     1, 7,    0, 0,  0,            1, 1, P7));
        vecs.push_back(mk(0, 0,  0,            0, 0,  0,            0, 0,    1, 7,  32'h7770,     0, 1, 0));
        vecs.push_back(mk(0, 0,  0,            1, 7,  32'h7A,       1, 7,    0, 0,  0,            1, 1, P7));
        vecs.push_back(mk(0, 0,  0,            0, 0,  0,            1, 7,    1, 7,  32'h7A,       0, 1, P7));
        vecs.push_back(mk(0, 0,  0,            0, 0,  0,            1, 0,    0, 0,  0,            0, 1, P7));
        vecs.push_back(mk(1, 10, 32'hA10,      1, 11, 32'hB11,      1, 11,   1, 10, 32'hA10,      1, 1, P7 | P11));
        vecs.push_back(mk(1, 12, 32'hA12,      1, 13, 32'hB13,      0, 0,    1, 12, 32'hA12,      2, 1, P7 | P11));
        vecs.push_back(mk(0, 0,  0,            1, 14, 32'hB14,      0, 0,    1, 11, 32'hB11,      2, 1, P7));
        vecs.push_back(mk(0, 0,  0,            1, 15, 32'hB15,      0, 0,    1, 13, 32'hB13,      2, 1, P7));
        vecs.push_back(mk(0, 0,  0,            1, 16, 32'hB16,      0, 0,    1, 14, 32'hB14,      2, 1, P7));
        vecs.push_back(mk(0, 0,  0,            0, 0,  0,            0, 0,    1, 15, 32'hB15,      1, 1, P7));
        vecs.push_back(mk(0, 0,  0,            0, 0,  0,            0, 0,    1, 16, 32'hB16,      0, 1, P7));
        vecs.push_back(mk(0, 0,  0,            0, 0,  0,            0, 0,    0, 0,  0,            0, 1, P7));

        repeat (2) @(posedge clk);
        #1;
        check("ready_in_reset", 64'(lsu_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_wr_en", 64'(wr_en), 64'd0);
        check("reset_pending", 64'(pending), 64'd0);
        check("reset_count", 64'(fifo_count), 64'd0);
        check("reset_ready", 64'(lsu_ready), 64'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].ad;
            lsu_valid = vecs[i].lv; lsu_rd = vecs[i].lrd; lsu_data = vecs[i].ld;
            pend_set  = vecs[i].ps; pend_rd = vecs[i].prd;
            sb.push_back(vecs[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            check($sformatf("v%0d_wr_en", i), 64'(wr_en), 64'(e.en));
            if (e.en) begin
                check($sformatf("v%0d_wr_rd", i), 64'(wr_rd), 64'(e.rd));
                check($sformatf("v%0d_wr_data", i), 64'(wr_data), 64'(e.data));
            end
            check($sformatf("v%0d_count", i), 64'(fifo_count), 64'(e.cnt));
            check($sformatf("v%0d_ready", i), 64'(lsu_ready), 64'(e.rdy));
            check($sformatf("v%0d_pending", i), 64'(pending), 64'(e.pend));
            check($sformatf("v%0d_stall", i), 64'(alu_stall), 64'd0);
        end

        // Idle cycles keep the last written address/data.
        check("hold_wr_rd", 64'(wr_rd), 64'd16);
        check("hold_wr_data", 64'(wr_data), 64'hB16);

        // Async reset mid-stream.
        @(negedge clk);
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 32'h88;
        pend_set = 1'b1; pend_rd = 5'd8;
        @(negedge clk);
        lsu_rd = 5'd9; lsu_data = 32'h99; pend_rd = 5'd9;
        @(posedge clk); #1;
        check("pre_rst_count", 64'(fifo_count), 64'd2);
        check("pre_rst_pending", 64'(pending), 64'h0000_0380);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_count", 64'(fifo_count), 64'd0);
        check("mid_rst_pending", 64'(pending), 64'd0);
        check("mid_rst_wr_en", 64'(wr_en), 64'd0);
        check("mid_rst_wr_rd", 64'(wr_rd), 64'd0);
        check("mid_rst_wr_data", 64'(wr_data), 64'd0);
        check("mid_rst_ready", 64'(lsu_ready), 64'd0);
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_count", 64'(fifo_count), 64'd0);
        check("post_rst_wr_en", 64'(wr_en), 64'd0);
        check("post_rst_ready", 64'(lsu_ready), 64'd1);

`ifdef WB_STARVE_GUARD_EN
        @(negedge clk);
        alu_valid = 1'b1; alu_rd = 5'd21; alu_data = 32'hA21;
        lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_data = 32'hC20;
        @(posedge clk); #1;
        check("starve_push_count", 64'(fifo_count), 64'd1);
        @(negedge clk);
        lsu_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            check($sformatf("starve_alu_%0d", k), 64'(wr_rd), 64'd21);
            check($sformatf("starve_stall_%0d", k), 64'(alu_stall), (k == 8) ? 64'd1 : 64'd0);
        end
        @(posedge clk); #1;
        check("forced_wr_en", 64'(wr_en), 64'd1);
        check("forced_wr_rd", 64'(wr_rd), 64'd20);
        check("forced_wr_data", 64'(wr_data), 64'hC20);
        check("forced_count", 64'(fifo_count), 64'd0);
        check("forced_stall_clear", 64'(alu_stall), 64'd0);
        @(posedge clk); #1;
        check("held_alu_rd", 64'(wr_rd), 64'd21);
        check("held_alu_data", 64'(wr_data), 64'hA21);
        @(negedge clk);
        idle_inputs();
`endif

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
